// File: rtl/logic_gate_unit_pkg.sv
// Shared opcode encoding and reference gate function for the logic gate unit.
// Imported by the pipeline stage, the top level and the bench.
package logic_gate_unit_pkg;

    localparam int LGU_OP_W  = 3;
    localparam int LGU_MAX_W = 64;

    typedef enum logic [LGU_OP_W-1:0] {
        LGU_AND  = 3'd0,
        LGU_OR   = 3'd1,
        LGU_NOT  = 3'd2,
        LGU_NAND = 3'd3,
        LGU_NOR  = 3'd4,
        LGU_XOR  = 3'd5,
        LGU_XNOR = 3'd6,
        LGU_BUF  = 3'd7
    } lgu_op_t;

    // Operands are zero-extended to LGU_MAX_W; callers slice the result
    function automatic logic [LGU_MAX_W-1:0] lgu_eval(
        input lgu_op_t              op,
        input logic [LGU_MAX_W-1:0] a,
        input logic [LGU_MAX_W-1:0] b
    );
        logic [LGU_MAX_W-1:0] r;
        r = '0;
        case (op)
            LGU_AND:  r = a & b;
            LGU_OR:   r = a | b;
            LGU_NOT:  r = ~a;
            LGU_NAND: r = ~(a & b);
            LGU_NOR:  r = ~(a | b);
            LGU_XOR:  r = a ^ b;
            LGU_XNOR: r = ~(a ^ b);
            LGU_BUF:  r = a;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_unit_stage.sv
// One valid/ready register stage with a parametrised payload.
// Accepts whenever empty or draining; in_ready is forced low during reset.
module lgu_pipe_stage
    import logic_gate_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        in_ready = !rst && (!valid_q || out_ready);
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready on both sides.
// Define LOGIC_GATE_UNIT_REDUCE_EN to add registered reduction outputs.
module logic_gate_unit
    import logic_gate_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [2:0]         out_op,
    output logic [COUNT_W-1:0] ops_done
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    ,
    output logic               out_red_and,
    output logic               out_red_or,
    output logic               out_red_xor
`endif
);

    localparam int S1_W = LGU_OP_W + 2 * WIDTH;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    localparam int RED_W = 3;
`else
    localparam int RED_W = 0;
`endif
    localparam int S2_W = LGU_OP_W + WIDTH + RED_W;

    logic [S1_W-1:0]     s1_in;
    logic [S1_W-1:0]     s1_out;
    logic                s1_valid;
    logic                s2_ready;
    logic [LGU_OP_W-1:0] s1_op;
    logic [WIDTH-1:0]    s1_a;
    logic [WIDTH-1:0]    s1_b;
    logic [WIDTH-1:0]    res;
    logic [S2_W-1:0]     s2_in;
    logic [S2_W-1:0]     s2_out;

    assign s1_in = {in_op, in_a, in_b};

    lgu_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    assign {s1_op, s1_a, s1_b} = s1_out;

    always_comb begin
        res = '0;
        case (lgu_op_t'(s1_op))
            LGU_AND:  res = s1_a & s1_b;
            LGU_OR:   res = s1_a | s1_b;
            LGU_NOT:  res = ~s1_a;
            LGU_NAND: res = ~(s1_a & s1_b);
            LGU_NOR:  res = ~(s1_a | s1_b);
            LGU_XOR:  res = s1_a ^ s1_b;
            LGU_XNOR: res = ~(s1_a ^ s1_b);
            LGU_BUF:  res = s1_a;
            default:  res = '0;
        endcase
    end

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    assign s2_in = {s1_op, res, &res, |res, ^res};
`else
    assign s2_in = {s1_op, res};
`endif

    lgu_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    assign {out_op, out_result, out_red_and, out_red_or, out_red_xor} = s2_out;
`else
    assign {out_op, out_result} = s2_out;
`endif

    logic [COUNT_W-1:0] ops_q;
    logic [COUNT_W-1:0] ops_d;

    always_comb begin
        ops_d = ops_q;
        if (out_valid && out_ready) begin
            ops_d = ops_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
        end else begin
            ops_q <= ops_d;
        end
    end

    assign ops_done = ops_q;

endmodule
